// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: write/read-back pattern soak tester driving an SDRAM controller request port.
// Define MEMTEST_ERR_CAPTURE_EN to build first-mismatch address/expected/actual capture registers.
module sdram_pattern_tester #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int ERR_W   = 8,
  parameter int PASS_W  = 16,
  parameter int OUTST_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   range_last,
  output logic [ADDR_W-1:0]   addr,
  output logic                rw,
  output logic [DATA_W-1:0]   data_in,
  output logic                in_valid,
  input  logic                busy,
  input  logic [DATA_W-1:0]   data_out,
  input  logic                out_valid,
  output logic                running,
  output logic                done,
  output logic [1:0]          phase,
  output logic [PASS_W-1:0]   pass_count,
  output logic [ERR_W-1:0]    err_count,
  output logic [DATA_W/8-1:0] lane_err,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_exp,
  output logic [DATA_W-1:0]   first_err_act
);
  localparam int NL = DATA_W / 8;
  localparam logic [OUTST_W-1:0] OMAX = '1;
  localparam logic [ERR_W-1:0] EMAX = '1;
  localparam logic [ADDR_W-1:0] DW = ADDR_W'(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    return y ^ (y << 5);
  endfunction

  function automatic logic [31:0] nz(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [DATA_W-1:0] word(input logic [1:0] m, input logic [31:0] g,
                                             input logic [ADDR_W-1:0] a);
    logic [63:0] r;
    logic [DATA_W+ADDR_W-1:0] e;
    logic [DATA_W-1:0] one;
    r = {g, g};
    e = {{DATA_W{1'b0}}, a};
    one = DATA_W'(1);
    return (m == 2'd0) ? r[DATA_W-1:0] : (m == 2'd1) ? e[DATA_W-1:0] :
           (m == 2'd2) ? ~e[DATA_W-1:0] : one << (a % DW);
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   range_q, range_d, iaddr_q, iaddr_d, caddr_q, caddr_d;
  logic [31:0]         igen_q, igen_d, cgen_q, cgen_d, seed_q, seed_d, seed_n;
  logic [OUTST_W-1:0]  outst_q, outst_d;
  logic                stop_q, stop_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [NL-1:0]       lane_q, lane_d, lane_diff;
  logic [DATA_W-1:0]   exp_w, diff;
  logic                wr_st, rd_st, wr_acc, rd_acc, chk, go, pass_end;

  assign wr_st    = state_q == S_WRITE;
  assign rd_st    = state_q == S_READ;
  assign in_valid = !busy && (wr_st || (rd_st && outst_q != OMAX));
  assign wr_acc   = in_valid && wr_st;
  assign rd_acc   = in_valid && rd_st;
  assign addr     = in_valid ? iaddr_q : '0;
  assign rw       = wr_acc;
  assign data_in  = wr_acc ? word(mode_q, igen_q, iaddr_q) : '0;
  assign chk      = out_valid && (rd_st || state_q == S_DRAIN);
  assign exp_w    = word(mode_q, cgen_q, caddr_q);
  assign diff     = exp_w ^ data_out;
  assign go       = start && (state_q == S_IDLE || state_q == S_DONE);
  assign pass_end = state_q == S_DRAIN && outst_q == '0;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    assign lane_diff[i] = |diff[8*i +: 8];
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    range_d = range_q;
    iaddr_d = iaddr_q;
    caddr_d = caddr_q;
    igen_d  = igen_q;
    cgen_d  = cgen_q;
    seed_d  = seed_q;
    seed_n  = (mode_q == 2'd0) ? seed_q + 32'd1 : seed_q;
    pass_d  = pass_q;
    err_d   = err_q;
    lane_d  = lane_q;
    stop_d  = go ? 1'b0 : (stop_q || stop);
    outst_d = outst_q + OUTST_W'(rd_acc) - OUTST_W'(chk);
    if (go) begin
      state_d = S_WRITE;
      mode_d  = mode;
      range_d = range_last;
      iaddr_d = '0;
      caddr_d = '0;
      igen_d  = nz(seed_q);
      cgen_d  = nz(seed_q);
      pass_d  = '0;
      err_d   = '0;
      lane_d  = '0;
    end
    if (wr_acc) begin
      iaddr_d = (iaddr_q == range_q) ? '0 : iaddr_q + 1'b1;
      igen_d  = (iaddr_q == range_q) ? nz(seed_q) : xs(igen_q);
      state_d = (iaddr_q == range_q) ? S_READ : S_WRITE;
    end
    if (rd_acc) begin
      iaddr_d = iaddr_q + 1'b1;
      state_d = (iaddr_q == range_q) ? S_DRAIN : S_READ;
    end
    if (chk) begin
      caddr_d = caddr_q + 1'b1;
      cgen_d  = xs(cgen_q);
      err_d   = (|diff && err_q != EMAX) ? err_q + 1'b1 : err_q;
      lane_d  = lane_q | lane_diff;
    end
    // Pass end: the next pass reuses the already-advanced seed for both generators.
    if (pass_end) begin
      pass_d  = pass_q + 1'b1;
      seed_d  = seed_n;
      state_d = (stop_q || stop || !loop) ? S_DONE : S_WRITE;
      iaddr_d = '0;
      caddr_d = '0;
      igen_d  = nz(seed_n);
      cgen_d  = nz(seed_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      range_q <= '0;
      iaddr_q <= '0;
      caddr_q <= '0;
      igen_q  <= '0;
      cgen_q  <= '0;
      seed_q  <= 32'h1;
      outst_q <= '0;
      stop_q  <= 1'b0;
      pass_q  <= '0;
      err_q   <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      range_q <= range_d;
      iaddr_q <= iaddr_d;
      caddr_q <= caddr_d;
      igen_q  <= igen_d;
      cgen_q  <= cgen_d;
      seed_q  <= seed_d;
      outst_q <= outst_d;
      stop_q  <= stop_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      lane_q  <= lane_d;
    end
  end

`ifdef MEMTEST_ERR_CAPTURE_EN
  logic              cap_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0] cap_exp_q, cap_act_q;

  always_ff @(posedge clk) begin
    if (rst || go) begin
      cap_q      <= 1'b0;
      cap_addr_q <= '0;
      cap_exp_q  <= '0;
      cap_act_q  <= '0;
    end else if (chk && |diff && !cap_q) begin
      cap_q      <= 1'b1;
      cap_addr_q <= caddr_q;
      cap_exp_q  <= exp_w;
      cap_act_q  <= data_out;
    end
  end

  assign first_err_addr = cap_addr_q;
  assign first_err_exp  = cap_exp_q;
  assign first_err_act  = cap_act_q;
`else
  assign first_err_addr = '0;
  assign first_err_exp  = '0;
  assign first_err_act  = '0;
`endif

  assign running    = wr_st || rd_st || state_q == S_DRAIN;
  assign done       = state_q == S_DONE;
  assign phase      = (state_q == S_IDLE) ? 2'd0 : wr_st ? 2'd1 : done ? 2'd3 : 2'd2;
  assign pass_count = pass_q;
  assign err_count  = err_q;
  assign lane_err   = lane_q;
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb_sdram_pattern_tester: directed scenarios against an SDRAM model with configurable
// read latency, busy toggling and read-data corruption.
module tb_sdram_pattern_tester;
  logic        clk, rst, start, stop, loop, busy, out_valid;
  logic [1:0]  mode;
  logic [22:0] rl, addr, first_err_addr;
  logic        rw, in_valid, running, done;
  logic [31:0] data_in, data_out, first_err_exp, first_err_act;
  logic [1:0]  phase;
  logic [15:0] pass_count;
  logic [7:0]  err_count;
  logic [3:0]  lane_err;

  sdram_pattern_tester dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop), .mode(mode),
    .range_last(rl), .addr(addr), .rw(rw), .data_in(data_in), .in_valid(in_valid),
    .busy(busy), .data_out(data_out), .out_valid(out_valid), .running(running),
    .done(done), .phase(phase), .pass_count(pass_count), .err_count(err_count),
    .lane_err(lane_err), .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, passed = 0;

  typedef struct { logic [31:0] d; int due; } rd_t;
  rd_t         rq[$];
  logic [31:0] mem [0:1023];
  logic [31:0] a0_q[$];
  logic [31:0] cmask = '0;
  logic [22:0] exp_wa = '0, exp_ra = '0;
  int cyc = 0, lat = 2, ocnt = 0, max_out = 0, wr_cnt = 0, rd_cnt = 0, seq_err = 0;
  int late_seen = 0, corrupt_addr = -1;
  bit corrupt_all = 0, busy_tog = 0;

  // Memory model: accepts requests at the clock edge, returns reads in order after lat cycles.
  always @(posedge clk) begin
    cyc++;
    if (out_valid) begin
      if (ocnt > 0) ocnt--;
      if (phase == 2'd0) late_seen++;
    end
    if (in_valid && !busy) begin
      if (rw) begin
        mem[addr[9:0]] = data_in;
        wr_cnt++;
        if (addr != exp_wa) seq_err++;
        exp_wa = (addr == rl) ? 23'd0 : addr + 23'd1;
        if (addr == 23'd0) a0_q.push_back(data_in);
      end else begin
        rq.push_back('{mem[addr[9:0]] ^ ((corrupt_all || int'(addr) == corrupt_addr) ? cmask : 32'd0), cyc + lat});
        rd_cnt++;
        ocnt++;
        if (addr != exp_ra) seq_err++;
        exp_ra = (addr == rl) ? 23'd0 : addr + 23'd1;
      end
    end
    if (rst) ocnt = 0;
    if (ocnt > max_out) max_out = ocnt;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      out_valid <= 1'b1;
      data_out  <= rq[0].d;
      void'(rq.pop_front());
    end else begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end
  end

  always @(negedge clk) if (busy_tog) busy = ~busy;

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_stats;
    wr_cnt = 0; rd_cnt = 0; seq_err = 0; max_out = 0;
    exp_wa = '0; exp_ra = '0;
    a0_q.delete();
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [22:0] r);
    mode = m; rl = r;
    clear_stats;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1) $display("FAIL %s timeout: done=%b after %0d cycles, want 1", tag, done, budget);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_valid, rw, addr, data_in} !== '0) $display("FAIL reset req: in_valid=%b rw=%b addr=%h data=%h want 0", in_valid, rw, addr, data_in);
    else passed++;
    checks++;
    if ({running, done, phase} !== 4'd0) $display("FAIL reset state: running=%b done=%b phase=%0d want 0", running, done, phase);
    else passed++;
    checks++;
    if ({pass_count, err_count, lane_err} !== '0) $display("FAIL reset counters: pass=%0d err=%0d lane=%b want 0", pass_count, err_count, lane_err);
    else passed++;
    checks++;
    if ({first_err_addr, first_err_exp, first_err_act} !== '0) $display("FAIL reset capture: %h %h %h want 0", first_err_addr, first_err_exp, first_err_act);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_prng;
    do_reset;
    lat = 2; loop = 1'b0;
    pulse_start(2'd0, 23'd63);
    checks++;
    if (phase !== 2'd1 || running !== 1'b1) $display("FAIL basic write phase: phase=%0d running=%b want 1/1", phase, running);
    else passed++;
    wait_done("basic", 2000);
    checks++;
    if (wr_cnt != 64 || rd_cnt != 64 || seq_err != 0) $display("FAIL basic traffic: wr=%0d rd=%0d seq_err=%0d want 64/64/0", wr_cnt, rd_cnt, seq_err);
    else passed++;
    checks++;
    if (pass_count !== 16'd1 || err_count !== 8'd0 || phase !== 2'd3 || running !== 1'b0) $display("FAIL basic status: pass=%0d err=%0d phase=%0d running=%b want 1/0/3/0", pass_count, err_count, phase, running);
    else passed++;
    checks++;
    if (mem[0] !== 32'h1 || mem[1] !== 32'h0004_2021) $display("FAIL basic prng words: %h %h want 00000001 00042021", mem[0], mem[1]);
    else passed++;
  endtask

  task automatic test_addr_corrupt;
    do_reset;
    corrupt_addr = 5; cmask = 32'h200;
    pulse_start(2'd1, 23'd63);
    wait_done("corrupt", 2000);
    corrupt_addr = -1;
    checks++;
    if (err_count !== 8'd1 || lane_err !== 4'b0010) $display("FAIL corrupt counts: err=%0d lane=%b want 1 0010", err_count, lane_err);
    else passed++;
    checks++;
    if (mem[5] !== 32'h5) $display("FAIL corrupt addr word: %h want 00000005", mem[5]);
    else passed++;
    checks++;
`ifdef MEMTEST_ERR_CAPTURE_EN
    if (first_err_addr !== 23'd5 || first_err_exp !== 32'h5 || first_err_act !== 32'h205) $display("FAIL corrupt capture: %h %h %h want 5 5 205", first_err_addr, first_err_exp, first_err_act);
`else
    if ({first_err_addr, first_err_exp, first_err_act} !== '0) $display("FAIL corrupt capture: %h %h %h want 0", first_err_addr, first_err_exp, first_err_act);
`endif
    else passed++;
  endtask

  task automatic test_modes;
    do_reset;
    pulse_start(2'd2, 23'd3);
    wait_done("mode2", 500);
    checks++;
    if (mem[0] !== 32'hFFFF_FFFF || mem[3] !== 32'hFFFF_FFFC || err_count !== 8'd0) $display("FAIL mode2 words: %h %h err=%0d want ffffffff fffffffc 0", mem[0], mem[3], err_count);
    else passed++;
    pulse_start(2'd3, 23'd40);
    wait_done("mode3", 1000);
    checks++;
    if (mem[31] !== 32'h8000_0000 || mem[32] !== 32'h1 || mem[33] !== 32'h2 || err_count !== 8'd0) $display("FAIL mode3 words: %h %h %h err=%0d want 80000000 1 2 0", mem[31], mem[32], mem[33], err_count);
    else passed++;
    pulse_start(2'd1, 23'd0);
    wait_done("range0", 500);
    checks++;
    if (wr_cnt != 1 || rd_cnt != 1 || pass_count !== 16'd1 || err_count !== 8'd0) $display("FAIL range0: wr=%0d rd=%0d pass=%0d err=%0d want 1/1/1/0", wr_cnt, rd_cnt, pass_count, err_count);
    else passed++;
  endtask

  task automatic test_outstanding;
    do_reset;
    lat = 20; busy_tog = 1;
    pulse_start(2'd0, 23'd63);
    wait_done("busy", 5000);
    busy_tog = 0; busy = 1'b0;
    checks++;
    if (wr_cnt != 64 || rd_cnt != 64 || seq_err != 0 || err_count !== 8'd0 || max_out > 15) $display("FAIL busy traffic: wr=%0d rd=%0d seq_err=%0d err=%0d max_out=%0d want 64/64/0/0/<=15", wr_cnt, rd_cnt, seq_err, err_count, max_out);
    else passed++;
    pulse_start(2'd0, 23'd63);
    wait_done("outst", 5000);
    checks++;
    if (max_out != 15 || rd_cnt != 64 || err_count !== 8'd0) $display("FAIL outst cap: max_out=%0d rd=%0d err=%0d want 15/64/0", max_out, rd_cnt, err_count);
    else passed++;
    lat = 2;
  endtask

  task automatic test_loop_stop;
    do_reset;
    loop = 1'b1;
    pulse_start(2'd0, 23'd15);
    for (int i = 0; i < 1000 && pass_count != 16'd2; i++) @(negedge clk);
    checks++;
    if (pass_count !== 16'd2 || phase !== 2'd1) $display("FAIL loop pass2: pass=%0d phase=%0d want 2/1", pass_count, phase);
    else passed++;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("loop", 1000);
    loop = 1'b0;
    checks++;
    if (pass_count !== 16'd3 || wr_cnt != 48 || rd_cnt != 48 || err_count !== 8'd0) $display("FAIL loop status: pass=%0d wr=%0d rd=%0d err=%0d want 3/48/48/0", pass_count, wr_cnt, rd_cnt, err_count);
    else passed++;
    checks++;
    if (a0_q.size() != 3) $display("FAIL loop seeds count: %0d want 3", a0_q.size());
    else if (a0_q[0] !== 32'h1 || a0_q[1] !== 32'h2 || a0_q[2] !== 32'h3) $display("FAIL loop seeds: %h %h %h want 1 2 3", a0_q[0], a0_q[1], a0_q[2]);
    else passed++;
  endtask

  task automatic test_saturate;
    do_reset;
    corrupt_all = 1; cmask = 32'hFFFF_FFFF;
    pulse_start(2'd1, 23'd511);
    wait_done("saturate", 5000);
    corrupt_all = 0;
    checks++;
    if (err_count !== 8'd255 || lane_err !== 4'hF || rd_cnt != 512) $display("FAIL saturate: err=%0d lane=%b rd=%0d want 255 1111 512", err_count, lane_err, rd_cnt);
    else passed++;
    checks++;
`ifdef MEMTEST_ERR_CAPTURE_EN
    if (first_err_addr !== 23'd0 || first_err_exp !== 32'h0 || first_err_act !== 32'hFFFF_FFFF) $display("FAIL saturate capture: %h %h %h want 0 0 ffffffff", first_err_addr, first_err_exp, first_err_act);
`else
    if ({first_err_addr, first_err_exp, first_err_act} !== '0) $display("FAIL saturate capture: %h %h %h want 0", first_err_addr, first_err_exp, first_err_act);
`endif
    else passed++;
  endtask

  task automatic test_reset_midread;
    do_reset;
    lat = 10; corrupt_all = 1; cmask = 32'hFFFF_FFFF;
    pulse_start(2'd1, 23'd63);
    for (int i = 0; i < 1000 && !(phase == 2'd2 && ocnt >= 3); i++) @(negedge clk);
    checks++;
    if (phase !== 2'd2 || ocnt != 3) $display("FAIL midread setup: phase=%0d outstanding=%0d want 2/3", phase, ocnt);
    else passed++;
    late_seen = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (in_valid !== 1'b0 || phase !== 2'd0 || err_count !== 8'd0 || lane_err !== 4'd0 || late_seen == 0) $display("FAIL midread idle: in_valid=%b phase=%0d err=%0d lane=%b late=%0d want 0/0/0/0/>0", in_valid, phase, err_count, lane_err, late_seen);
    else passed++;
    corrupt_all = 0; lat = 2;
    pulse_start(2'd1, 23'd63);
    wait_done("midread rerun", 2000);
    checks++;
    if (pass_count !== 16'd1 || err_count !== 8'd0 || rd_cnt != 64 || seq_err != 0) $display("FAIL midread rerun: pass=%0d err=%0d rd=%0d seq_err=%0d want 1/0/64/0", pass_count, err_count, rd_cnt, seq_err);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; busy = 1'b0;
    mode = 2'd0; rl = '0;
    test_reset;
    test_basic_prng;
    test_addr_corrupt;
    test_modes;
    test_outstanding;
    test_loop_stop;
    test_saturate;
    test_reset_midread;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sdram_pattern_tester.md
Name: sdram_pattern_tester

Overview:
Parametrised successor to the LED SDRAM soak tester: drives the SDRAM controller request port (addr/rw/data_in/in_valid/busy, data_out/out_valid) and checks memory. Sequence per pass: write a pattern over addresses 0..range_last, read back, compare. Adds selectable patterns, start/stop/loop control, pass and error counters, and a drain phase that waits for all outstanding reads. Status readable by the MicroBlaze MCS IO bus or LEDs.

Parameters:
ADDR_W, 23, controller word-address width
DATA_W, 32, data width; multiple of 8, range 8..64
ERR_W, 8, error counter width (saturating)
PASS_W, 16, pass counter width (wrapping)
OUTST_W, 4, outstanding-read counter width; max 2^OUTST_W-1 reads in flight

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin test (IDLE or DONE only)
stop  in  1  pulse: finish current pass then go DONE
loop  in  1  level: repeat passes; sampled at pass end
mode  in  2  pattern: 0 PRNG, 1 address, 2 ~address, 3 walking-one; latched on start
range_last  in  ADDR_W  last tested address; latched on start
addr  out  ADDR_W  request address
rw  out  1  1 = write, 0 = read
data_in  out  DATA_W  write data
in_valid  out  1  request valid
busy  in  1  controller cannot accept a request
data_out  in  DATA_W  read data
out_valid  in  1  read data valid, one cycle per read, in issue order
running  out  1  state is not IDLE/DONE
done  out  1  state is DONE
phase  out  2  0 IDLE, 1 WRITE, 2 READ/DRAIN, 3 DONE
pass_count  out  PASS_W  completed passes
err_count  out  ERR_W  mismatched words, saturating
lane_err  out  DATA_W/8  per-byte sticky mismatch flags
first_err_addr  out  ADDR_W  address of first mismatch
first_err_exp  out  DATA_W  expected word at first mismatch
first_err_act  out  DATA_W  actual word at first mismatch

Behaviour:
- Reset: state IDLE; every output 0; seed 32'h1; counters, flags and captures 0. Reset mid-transaction drops it; reads returned later while IDLE are ignored.
- Request accepted when in_valid && !busy. in_valid is combinational: asserted only when !busy and state WRITE or READ (READ also needs outstanding < 2^OUTST_W-1). addr/rw/data_in are 0 when in_valid=0.
- Generator: xorshift32 (x^=x<<13; x^=x>>17; x^=x<<5); a zero seed is replaced with 1. Word = 32-bit value replicated, truncated to DATA_W. Address modes zero-extend/truncate addr to DATA_W. Walking-one word = 1<<(addr mod DATA_W).
- Two generators, both reset to the seed at pass start: issue (steps on each accepted write) and check (steps on each out_valid).
- Check address counter starts at 0 and increments on out_valid; it gives the expected value for the address modes.
- IDLE/DONE: start -> latch mode and range_last, clear err_count, lane_err, captures and pass_count; go WRITE with issue addr 0. start in any other state is ignored.
- WRITE: issue writes to addresses 0..range_last. When write range_last is accepted: go READ, issue addr 0, reset the issue generator.
- READ: issue reads to 0..range_last. When read range_last is accepted: go DRAIN.
- Outstanding counter: +1 on accepted read, -1 on out_valid; both in the same cycle -> unchanged.
- DRAIN: when outstanding is 0 (after the last out_valid), the pass ends. pass_count+1; seed+1 (PRNG mode only). If stop was seen during the pass, or loop=0 -> DONE. Otherwise -> WRITE.
- Compare (states READ/DRAIN, on out_valid): a mismatch increments err_count, saturating at 2^ERR_W-1. lane_err[i] |= byte i differs. out_valid in IDLE/WRITE/DONE is ignored.
- range_last = 0: one-word pass. range_last = all ones: full wrap of the address counter without overflow glitch (compare, don't rely on carry).
- stop is latched into a sticky flag, cleared at start.

Optional Feature:
MEMTEST_ERR_CAPTURE_EN
- Defined: on the first mismatch since start, first_err_addr/exp/act are captured and then held.
- Not defined: the three capture outputs are tied to 0 and no capture registers are built. err_count and lane_err are unaffected.

Test Plan:
- Ideal memory model with 2-cycle read latency, range_last=63, mode 0, loop=0, start -> 64 writes then 64 reads; pass_count=1; err_count=0; done=1; phase=3.
- Model corrupts bit 9 at addr 5, mode 1 -> err_count=1; lane_err=4'b0010; with capture: first_err_addr=5, first_err_exp=32'h5, first_err_act=32'h205.
- busy toggles every other cycle and read latency is 20 cycles with OUTST_W=4 -> outstanding never exceeds 15; no dropped or duplicated request; err_count=0.
- loop=1, stop pulsed during pass 3 -> pass 3 completes; pass_count=3; done=1; pass 2 PRNG data differs from pass 1 (seed+1).
- Every address fails, ERR_W=8, range_last=511 -> err_count saturates at 255.
- rst asserted in READ with 3 reads outstanding; late out_valid arrives -> in_valid=0, err_count=0, state IDLE; a following start runs a clean pass.
